// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch/decode instruction buffer.
// Opcode constants and immediate-format select codes.
package inst_buffer_pkg;

    localparam logic [2:0] IM0    = 3'd0;
    localparam logic [2:0] IM3    = 3'd1;
    localparam logic [2:0] IM4    = 3'd2;
    localparam logic [2:0] IM5    = 3'd3;
    localparam logic [2:0] IM8    = 3'd4;
    localparam logic [2:0] IM11   = 3'd5;
    localparam logic [2:0] IM_TO8 = 3'd6;

    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_BNEZ   = 5'b00101;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_SLTI   = 5'b01010;
    localparam logic [4:0] OP_ADDSP  = 5'b01100;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_CMPI   = 5'b01110;
    localparam logic [4:0] OP_LW_SP  = 5'b10010;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW_SP  = 5'b11010;
    localparam logic [4:0] OP_SW     = 5'b11011;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } ib_entry_t;

endpackage

// File: rtl/inst_buffer_imm_sel_decode.sv
// Immediate-format select decoder; combinational and reusable
// by any stage that needs the format code of an instruction.
module imm_sel_decode
    import inst_buffer_pkg::*;
(
    input  logic [15:0] inst,
    input  logic        valid,
    output logic [2:0]  sel
);

    logic [4:0] op;

    assign op = inst[15:11];

    always_comb begin
        sel = IM0;
        if (valid) begin
            case (op)
                OP_LW, OP_SW, OP_LW_SP, OP_SW_SP:
                    sel = IM5;
                OP_ADDIU, OP_LI, OP_BEQZ, OP_BNEZ,
                OP_SLTI, OP_CMPI, OP_ADDSP:
                    sel = IM8;
                OP_ADDIU3:
                    sel = IM4;
                OP_B:
                    sel = IM11;
                // zero shift field encodes a shift by 8
                OP_SHIFT:
                    sel = (inst[4:2] != 3'd0) ? IM3 : IM_TO8;
                default:
                    sel = IM0;
            endcase
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Two-entry fetch/decode instruction buffer with redirect flush.
// Optional same-cycle bypass when empty: define IBUF_BYPASS_EN.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [15:0] f_inst,
    input  logic [15:0] f_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [15:0] d_inst,
    output logic [15:0] d_pc,
    output logic [10:0] imm_src,
    output logic [2:0]  imm_sel
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    ib_entry_t  mem [2];
    logic       rptr;
    logic       wptr;
    logic [1:0] count;
    logic       wr;
    logic       rd;
    logic       byp_take;
    ib_entry_t  head;

    assign f_ready = (count != FULL);
    assign rd      = (count != 2'd0) && d_ready;

`ifdef IBUF_BYPASS_EN
    logic byp;

    assign byp      = (count == 2'd0) && f_valid && !flush;
    assign byp_take = byp && d_ready;
    assign d_valid  = (count != 2'd0) || byp;
    assign head     = byp ? '{inst: f_inst, pc: f_pc} : mem[rptr];
`else
    assign byp_take = 1'b0;
    assign d_valid  = (count != 2'd0);
    assign head     = mem[rptr];
`endif

    // a bypassed entry goes straight to decode and is never stored
    assign wr = f_valid && f_ready && !byp_take;

    assign d_inst  = head.inst;
    assign d_pc    = head.pc;
    assign imm_src = head.inst[10:0];

    imm_sel_decode u_dec (
        .inst  (head.inst),
        .valid (d_valid),
        .sel   (imm_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= '{inst: f_inst, pc: f_pc};
            end
            wptr  <= wptr ^ wr;
            rptr  <= rptr ^ rd;
            count <= count + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        f_valid;
    logic        f_ready;
    logic [15:0] f_inst;
    logic [15:0] f_pc;
    logic        d_valid;
    logic        d_ready;
    logic [15:0] d_inst;
    logic [15:0] d_pc;
    logic [10:0] imm_src;
    logic [2:0]  imm_sel;

    int checks = 0;
    int errors = 0;

    inst_buffer #(.DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f_inst  (f_inst),
        .f_pc    (f_pc),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_inst  (d_inst),
        .d_pc    (d_pc),
        .imm_src (imm_src),
        .imm_sel (imm_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] p);
        f_valid = 1'b1;
        f_inst  = i;
        f_pc    = p;
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        f_valid = 1'b0;
        f_inst  = 16'h0;
        f_pc    = 16'h0;
        d_ready = 1'b0;
        step();
        step();
        chk("rst d_valid", 32'(d_valid), 32'd0);
        chk("rst f_ready", 32'(f_ready), 32'd1);
        chk("rst imm_sel", 32'(imm_sel), 32'(IM0));
        chk("rst d_inst", 32'(d_inst), 32'h0);
        chk("rst d_pc", 32'(d_pc), 32'h0);
        chk("rst imm_src", 32'(imm_src), 32'h0);
        rst = 1'b0;
        step();

        // fill while decode stalls
        push(16'h4A05, 16'h0010);
        step();
        chk("fill1 d_valid", 32'(d_valid), 32'd1);
        chk("fill1 f_ready", 32'(f_ready), 32'd1);
        chk("fill1 d_inst", 32'(d_inst), 32'h4A05);
        push(16'h1003, 16'h0011);
        step();
        chk("full f_ready", 32'(f_ready), 32'd0);
        chk("full d_inst", 32'(d_inst), 32'h4A05);
        chk("full d_pc", 32'(d_pc), 32'h0010);
        chk("full imm_sel", 32'(imm_sel), 32'(IM8));
        chk("full imm_src", 32'(imm_src), 32'h205);
        push(16'hFFFF, 16'h0099);
        step();
        chk("ign d_inst", 32'(d_inst), 32'h4A05);
        chk("ign f_ready", 32'(f_ready), 32'd0);
        f_valid = 1'b0;

        // drain
        d_ready = 1'b1;
        step();
        chk("drain1 d_inst", 32'(d_inst), 32'h1003);
        chk("drain1 d_pc", 32'(d_pc), 32'h0011);
        chk("drain1 imm_sel", 32'(imm_sel), 32'(IM11));
        chk("drain1 f_ready", 32'(f_ready), 32'd1);
        step();
        chk("drain2 d_valid", 32'(d_valid), 32'd0);
        chk("drain2 imm_sel", 32'(imm_sel), 32'(IM0));

        // shift decode
        d_ready = 1'b0;
        push(16'h3100, 16'h0020);
        step();
        chk("shf8 imm_sel", 32'(imm_sel), 32'(IM_TO8));
        d_ready = 1'b1;
        push(16'h310C, 16'h0021);
        step();
        chk("shf3 d_inst", 32'(d_inst), 32'h310C);
        chk("shf3 imm_sel", 32'(imm_sel), 32'(IM3));
        chk("shf3 amt", 32'(imm_src[4:2]), 32'd3);

        // simultaneous push/pop at count 1
        for (int i = 0; i < 8; i++) begin
            push(16'h4800 | 16'(i), 16'h0100 + 16'(i));
            step();
            chk("pp d_pc", 32'(d_pc), 32'h0100 + 32'(i));
            chk("pp d_valid", 32'(d_valid), 32'd1);
            chk("pp f_ready", 32'(f_ready), 32'd1);
        end

        // flush while full
        d_ready = 1'b0;
        push(16'h4801, 16'h0200);
        step();
        chk("pre-flush f_ready", 32'(f_ready), 32'd0);
        flush = 1'b1;
        push(16'h4802, 16'h0201);
        step();
        flush   = 1'b0;
        f_valid = 1'b0;
        chk("flush d_valid", 32'(d_valid), 32'd0);
        chk("flush f_ready", 32'(f_ready), 32'd1);
        chk("flush imm_sel", 32'(imm_sel), 32'(IM0));
        step();
        chk("flush discard", 32'(d_valid), 32'd0);

        // refill after flush
        push(16'h6805, 16'h0300);
        step();
        f_valid = 1'b0;
        chk("refill d_pc", 32'(d_pc), 32'h0300);
        chk("refill imm_sel", 32'(imm_sel), 32'(IM8));
        step();
        chk("stall hold d_pc", 32'(d_pc), 32'h0300);

        // async reset mid-stall
        #2;
        rst = 1'b1;
        #1;
        chk("arst d_valid", 32'(d_valid), 32'd0);
        chk("arst f_ready", 32'(f_ready), 32'd1);
        chk("arst imm_sel", 32'(imm_sel), 32'(IM0));
        chk("arst d_inst", 32'(d_inst), 32'h0);
        step();
        rst = 1'b0;
        step();

`ifdef IBUF_BYPASS_EN
        d_ready = 1'b1;
        push(16'h1234, 16'h0400);
        #1;
        chk("byp d_valid", 32'(d_valid), 32'd1);
        chk("byp d_pc", 32'(d_pc), 32'h0400);
        chk("byp imm_sel", 32'(imm_sel), 32'(IM11));
        step();
        f_valid = 1'b0;
        #1;
        chk("byp not stored", 32'(d_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
